// File: rtl/mem_arbiter.sv
// Memory arbiter between the icache/dcache and a single RAM port.
// Data requests win unless a fetch is owed after a data grant; a watchdog bounds every access.
module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } state_t;

    localparam logic [31:0]     BAD_WORD = 32'hBAD0BAD0;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            last_d_q, last_d_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     store_q, store_d;
    logic            wen_q, wen_d;
    logic            expired;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wen_q    <= wen_d;
        end
    end

    // ramready on the last watchdog cycle counts as a normal completion, so expired excludes it.
    assign expired = (cnt_q == CNT_LAST) && !ramready;
    assign err     = err_q;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wen_d    = wen_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((dREN || dWEN) && !(last_d_q && iREN)) begin
                    state_d  = DGRANT;
                    addr_d   = daddr;
                    store_d  = dstore;
                    wen_d    = dWEN;
                    last_d_d = 1'b1;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    addr_d   = iaddr;
                    last_d_d = 1'b0;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                cnt_d   = cnt_q + CNTW'(1);
                if (!iREN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ramready || expired) begin
                    iwait   = 1'b0;
                    iload   = expired ? BAD_WORD : ramload;
                    err_d   = err_q | expired;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            DGRANT: begin
                ramREN   = !wen_q;
                ramWEN   = wen_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                cnt_d    = cnt_q + CNTW'(1);
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ramready || expired) begin
                    dwait   = 1'b0;
                    dload   = expired ? BAD_WORD : (wen_q ? 32'h0 : ramload);
                    err_d   = err_q | expired;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with fixed expectations, then random traffic
// compared against a transaction-level model of ownership, priority and the watchdog.
module tb_mem_arbiter;

    localparam int          TIMEOUT = 8;
    localparam int          CNTW    = 4;
    localparam logic [31:0] BAD     = 32'hBAD0BAD0;

    logic        CLK, nRST;
    logic        iREN, iwait, dREN, dWEN, dwait;
    logic        ramREN, ramWEN, ramready, err;
    logic [31:0] iaddr, iload, daddr, dstore, dload;
    logic [31:0] ramaddr, ramstore, ramload;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramready = 1'b0; ramload = 32'h0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h1; daddr = 32'h2; dstore = 32'h3;
        ramready = 1'b0; ramload = 32'h0;
        next_cycle(); next_cycle(); settle();
        checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("[TB] FAIL reset_wait: got %b expected 11", {iwait, dwait}); end
        checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'b0) begin errors++; $display("[TB] FAIL reset_ram: got %b %b %h %h expected all zero", ramREN, ramWEN, ramaddr, ramstore); end
        checks++; if ({iload, dload} !== 64'b0) begin errors++; $display("[TB] FAIL reset_load: got %h %h expected 0 0", iload, dload); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        next_cycle();
        nRST = 1'b1; idle_inputs();
        settle();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: ramREN got %b expected 0", ramREN); end
        next_cycle();
    endtask

    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h0000_0040;
        settle();
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("[TB] FAIL fetch_idle: ramREN,iwait got %b expected 01", {ramREN, iwait}); end
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            ramready = (c == 3);
            ramload  = (c == 3) ? 32'h2402_0001 : 32'hDEAD_BEEF;
            settle();
            checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin errors++; $display("[TB] FAIL fetch_ram c%0d: got %b%b %h expected 10 00000040", c, ramREN, ramWEN, ramaddr); end
            checks++; if (iwait !== (c != 3)) begin errors++; $display("[TB] FAIL fetch_iwait c%0d: got %b expected %b", c, iwait, (c != 3)); end
            if (c == 3) begin
                checks++; if (iload !== 32'h2402_0001) begin errors++; $display("[TB] FAIL fetch_iload: got %h expected 24020001", iload); end
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL fetch_back_idle: ramREN got %b expected 0", ramREN); end
        next_cycle();
    endtask

    task automatic test_conflict();
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h80;
        settle();
        checks++; if ({ramREN, iwait, dwait} !== 3'b011) begin errors++; $display("[TB] FAIL conflict_idle: got %b expected 011", {ramREN, iwait, dwait}); end
        next_cycle();
        ramready = 1'b1; ramload = 32'h1111_2222;
        settle();
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h80}) begin errors++; $display("[TB] FAIL conflict_dgrant: got %b %h expected 1 00000080", ramREN, ramaddr); end
        checks++; if ({iwait, dwait, dload} !== {2'b10, 32'h1111_2222}) begin errors++; $display("[TB] FAIL conflict_dcomplete: got %b%b %h expected 10 11112222", iwait, dwait, dload); end
        next_cycle();
        ramready = 1'b0;
        settle();
        checks++; if ({ramREN, iwait, dwait} !== 3'b011) begin errors++; $display("[TB] FAIL conflict_gap: got %b expected 011", {ramREN, iwait, dwait}); end
        next_cycle();
        ramready = 1'b1; ramload = 32'h3333_4444;
        settle();
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h200}) begin errors++; $display("[TB] FAIL conflict_igrant: got %b %h expected 1 00000200", ramREN, ramaddr); end
        checks++; if ({iwait, dwait, iload} !== {2'b01, 32'h3333_4444}) begin errors++; $display("[TB] FAIL conflict_icomplete: got %b%b %h expected 01 33334444", iwait, dwait, iload); end
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
    endtask

    task automatic test_write();
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE_F00D;
        settle();
        next_cycle();
        ramready = 1'b1; ramload = 32'h5555_5555;
        settle();
        checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("[TB] FAIL write_strobes: got %b expected 10", {ramWEN, ramREN}); end
        checks++; if ({ramaddr, ramstore} !== {32'h100, 32'hCAFE_F00D}) begin errors++; $display("[TB] FAIL write_bus: got %h %h expected 00000100 cafef00d", ramaddr, ramstore); end
        checks++; if ({dwait, dload} !== 33'h0) begin errors++; $display("[TB] FAIL write_done: got %b %h expected 0 00000000", dwait, dload); end
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
    endtask

    task automatic test_ready_at_timeout();
        iREN = 1'b1; iaddr = 32'h500;
        settle();
        next_cycle();
        for (int c = 1; c <= TIMEOUT; c++) begin
            ramready = (c == TIMEOUT); ramload = 32'h0F0F_0F0F;
            settle();
            checks++; if (iwait !== (c != TIMEOUT)) begin errors++; $display("[TB] FAIL tie_iwait c%0d: got %b expected %b", c, iwait, (c != TIMEOUT)); end
            next_cycle();
        end
        idle_inputs();
        settle();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL tie_err: got %b expected 0", err); end
        next_cycle();
    endtask

    task automatic test_timeout();
        iREN = 1'b1; iaddr = 32'h300; ramready = 1'b0;
        settle();
        next_cycle();
        for (int c = 1; c <= TIMEOUT; c++) begin
            settle();
            checks++; if (iwait !== (c != TIMEOUT)) begin errors++; $display("[TB] FAIL timeout_iwait c%0d: got %b expected %b", c, iwait, (c != TIMEOUT)); end
            if (c == TIMEOUT) begin
                checks++; if ({iload, err} !== {BAD, 1'b0}) begin errors++; $display("[TB] FAIL timeout_load: got %h %b expected bad0bad0 0", iload, err); end
            end
            next_cycle();
        end
        iREN = 1'b0;
        settle();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
        next_cycle();
        iREN = 1'b1; iaddr = 32'h44;
        settle();
        next_cycle();
        ramready = 1'b1; ramload = 32'h1234_5678;
        settle();
        checks++; if ({iwait, iload, err} !== {1'b0, 32'h1234_5678, 1'b1}) begin errors++; $display("[TB] FAIL timeout_sticky: got %b %h %b expected 0 12345678 1", iwait, iload, err); end
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
    endtask

    task automatic test_abort();
        dREN = 1'b1; daddr = 32'h400;
        settle();
        next_cycle();
        settle();
        checks++; if ({ramREN, dwait} !== 2'b11) begin errors++; $display("[TB] FAIL abort_grant: got %b expected 11", {ramREN, dwait}); end
        next_cycle();
        dREN = 1'b0;
        settle();
        checks++; if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h400, 1'b1}) begin errors++; $display("[TB] FAIL abort_cycle: got %b %h %b expected 1 00000400 1", ramREN, ramaddr, dwait); end
        next_cycle();
        settle();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: ramREN got %b expected 0", ramREN); end
        next_cycle();
    endtask

    task automatic test_reset_mid_grant();
        iREN = 1'b1; iaddr = 32'h600;
        settle();
        next_cycle();
        settle();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("[TB] FAIL rstgrant_grant: ramREN got %b expected 1", ramREN); end
        next_cycle();
        nRST = 1'b0;
        next_cycle();
        settle();
        checks++; if ({ramREN, err, iwait} !== 3'b001) begin errors++; $display("[TB] FAIL rstgrant_idle: got %b expected 001", {ramREN, err, iwait}); end
        next_cycle();
        nRST = 1'b1; idle_inputs();
        settle();
        next_cycle();
    endtask

    task automatic test_random();
        int    owner;
        int    age;
        bit    fetch_owed, m_err, m_write;
        bit    i_act, d_act, held, timed_out, finished;
        bit    e_iwait, e_dwait, e_rren, e_rwen;
        int    kind;
        logic [31:0] m_addr, m_store, e_iload, e_dload, e_addr, e_store;

        nRST = 1'b0; idle_inputs();
        next_cycle();
        nRST = 1'b1;
        owner = 0; age = 0; fetch_owed = 0; m_err = 0; m_write = 0;
        m_addr = 0; m_store = 0; i_act = 0; d_act = 0; kind = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_act && $urandom_range(3) == 0) begin i_act = 1; iaddr = $urandom; end
            else if (i_act && $urandom_range(63) == 0) i_act = 0;
            if (i_act && $urandom_range(31) == 0) iaddr = $urandom;
            if (!d_act && $urandom_range(3) == 0) begin
                d_act = 1; kind = $urandom_range(2); daddr = $urandom; dstore = $urandom;
            end else if (d_act && $urandom_range(63) == 0) d_act = 0;
            if (d_act && $urandom_range(31) == 0) daddr = $urandom;
            iREN = i_act;
            dREN = d_act && (kind != 1);
            dWEN = d_act && (kind != 0);
            ramready = ($urandom_range(4) == 0);
            ramload  = $urandom;
            settle();

            held      = (owner == 1) ? iREN : (owner == 2) ? (dREN || dWEN) : 1'b0;
            timed_out = held && !ramready && (age + 1 == TIMEOUT);
            finished  = held && (ramready || timed_out);
            e_iwait   = !(owner == 1 && finished);
            e_dwait   = !(owner == 2 && finished);
            e_iload   = (owner == 1 && finished) ? (timed_out ? BAD : ramload) : 32'h0;
            e_dload   = (owner == 2 && finished) ? (timed_out ? BAD : (m_write ? 32'h0 : ramload)) : 32'h0;
            e_rren    = (owner == 1) || (owner == 2 && !m_write);
            e_rwen    = (owner == 2) && m_write;
            e_addr    = (owner != 0) ? m_addr : 32'h0;
            e_store   = (owner == 2) ? m_store : 32'h0;

            checks++; if ({iwait, dwait} !== {e_iwait, e_dwait}) begin errors++; $display("[TB] FAIL rand_wait cyc%0d: got %b%b expected %b%b", cyc, iwait, dwait, e_iwait, e_dwait); end
            checks++; if ({iload, dload} !== {e_iload, e_dload}) begin errors++; $display("[TB] FAIL rand_load cyc%0d: got %h %h expected %h %h", cyc, iload, dload, e_iload, e_dload); end
            checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== {e_rren, e_rwen, e_addr, e_store}) begin errors++; $display("[TB] FAIL rand_ram cyc%0d: got %b%b %h %h expected %b%b %h %h", cyc, ramREN, ramWEN, ramaddr, ramstore, e_rren, e_rwen, e_addr, e_store); end
            checks++; if (err !== m_err) begin errors++; $display("[TB] FAIL rand_err cyc%0d: got %b expected %b", cyc, err, m_err); end

            // A finished or abandoned grant always leaves one free cycle before the next decision.
            if (owner != 0) begin
                if (!held || finished) begin
                    owner = 0; age = 0;
                    if (timed_out) m_err = 1;
                end else begin
                    age++;
                end
            end else if ((dREN || dWEN) && !(fetch_owed && iREN)) begin
                owner = 2; m_addr = daddr; m_store = dstore; m_write = dWEN; fetch_owed = 1;
            end else if (iREN) begin
                owner = 1; m_addr = iaddr; fetch_owed = 0;
            end

            if (iREN && !e_iwait) i_act = 0;
            if ((dREN || dWEN) && !e_dwait) d_act = 0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        nRST = 1'b0; iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_fetch();
        test_conflict();
        test_write();
        test_ready_at_timeout();
        test_timeout();
        test_abort();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
